// File: rtl/t2mi_frame_scheduler.sv
// Per-frame T2-MI packet sequencer: timestamp (optional), L1-current, then BBF_PER_FRAME BBFrames.
// Define T2MI_TIMESTAMP_PKT_EN to emit the timestamp packet at the start of each frame.
module t2mi_frame_scheduler #(
  parameter int unsigned N_T2_FRAMES = 2,
  parameter int unsigned SF_IDX_W    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENABLE,
  input  logic                FRAME_TICK,
  input  logic                BBF_READY,
  input  logic                PKT_DONE,
  input  logic [7:0]          BBF_PER_FRAME,
  output logic                PKT_START,
  output logic [7:0]          PKT_TYPE,
  output logic [7:0]          PKT_COUNT,
  output logic [7:0]          FRAME_IDX,
  output logic [SF_IDX_W-1:0] SUPERFRAME_IDX,
  output logic                L1_LOAD,
  output logic                BUSY,
  output logic                OVERRUN
);

  typedef enum logic [2:0] {
    IDLE, TS_REQ, TS_WAIT, L1_REQ, L1_WAIT, BB_REQ, BB_WAIT, FRAME_END
  } state_t;

  localparam logic [7:0] TYPE_TS    = 8'h20;
  localparam logic [7:0] TYPE_L1    = 8'h10;
  localparam logic [7:0] TYPE_BB    = 8'h00;
  localparam logic [7:0] FRAME_LAST = 8'(N_T2_FRAMES - 1);

  state_t     state;
  logic       pending;
  logic [7:0] bb_left;

  assign BUSY = (state != IDLE) && (state != FRAME_END);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      pending        <= 1'b0;
      bb_left        <= '0;
      PKT_START      <= 1'b0;
      PKT_TYPE       <= TYPE_BB;
      PKT_COUNT      <= '0;
      FRAME_IDX      <= '0;
      SUPERFRAME_IDX <= '0;
      L1_LOAD        <= 1'b0;
      OVERRUN        <= 1'b0;
    end else begin
      PKT_START <= 1'b0;
      L1_LOAD   <= 1'b0;
      if (PKT_START) PKT_COUNT <= PKT_COUNT + 8'd1;

      // Ticks arriving mid-frame queue one frame; a second queued tick is lost.
      if (FRAME_TICK && ENABLE && (state != IDLE)) begin
        if (pending) OVERRUN <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!ENABLE) begin
            pending <= 1'b0;
          end else if (FRAME_TICK || pending) begin
            pending   <= 1'b0;
            bb_left   <= BBF_PER_FRAME;
            PKT_START <= 1'b1;
            L1_LOAD   <= 1'b1;
`ifdef T2MI_TIMESTAMP_PKT_EN
            state     <= TS_REQ;
            PKT_TYPE  <= TYPE_TS;
`else
            state     <= L1_REQ;
            PKT_TYPE  <= TYPE_L1;
`endif
          end
        end
`ifdef T2MI_TIMESTAMP_PKT_EN
        TS_REQ: state <= TS_WAIT;
        TS_WAIT: begin
          if (PKT_DONE) begin
            if (!ENABLE) begin
              state   <= IDLE;
              pending <= 1'b0;
            end else begin
              state     <= L1_REQ;
              PKT_START <= 1'b1;
              PKT_TYPE  <= TYPE_L1;
            end
          end
        end
`endif
        L1_REQ: state <= L1_WAIT;
        L1_WAIT: begin
          if (PKT_DONE) begin
            if (!ENABLE) begin
              state   <= IDLE;
              pending <= 1'b0;
            end else if (bb_left == 8'd0) begin
              state <= FRAME_END;
            end else if (BBF_READY) begin
              state     <= BB_WAIT;
              PKT_START <= 1'b1;
              PKT_TYPE  <= TYPE_BB;
            end else begin
              state <= BB_REQ;
            end
          end
        end
        // BB_REQ only waits for BBF_READY; the BB start pulse coincides with entry to BB_WAIT.
        BB_REQ: begin
          if (!ENABLE) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else if (BBF_READY) begin
            state     <= BB_WAIT;
            PKT_START <= 1'b1;
            PKT_TYPE  <= TYPE_BB;
          end
        end
        BB_WAIT: begin
          if (PKT_DONE) begin
            bb_left <= bb_left - 8'd1;
            if (!ENABLE) begin
              state   <= IDLE;
              pending <= 1'b0;
            end else if (bb_left == 8'd1) begin
              state <= FRAME_END;
            end else if (BBF_READY) begin
              PKT_START <= 1'b1;
              PKT_TYPE  <= TYPE_BB;
            end else begin
              state <= BB_REQ;
            end
          end
        end
        FRAME_END: begin
          state <= IDLE;
          if (FRAME_IDX == FRAME_LAST) begin
            FRAME_IDX      <= '0;
            SUPERFRAME_IDX <= SUPERFRAME_IDX + SF_IDX_W'(1);
          end else begin
            FRAME_IDX <= FRAME_IDX + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
